shift_arbiter: RTL and testbench

- Shares one memory-mapped shifter peripheral between two requesters.
- Register map of the peripheral:
  - sel 00: info register; bit15 = direction, bits 14:0 = count, saturated to 15 by the peripheral.
  - sel 01: original value.
  - sel 10: shift result.
  - sel 11: ready; selecting it restarts the shifter.
- The block arbitrates round-robin, latches the winning job, sequences the bus writes, restart, wait and result read, then returns the result with a done pulse.

---
 rtl/shift_arbiter_if.sv | 28 ++
 rtl/shift_arbiter.sv | 155 +++++++++++++++
 tb/tb_shift_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Requester handshake and shifter peripheral bus shared by shift_arbiter.
// master is the arbiter side; slave is the requesters plus peripheral.
interface shift_arbiter_if;
  logic [1:0]  req_valid;
  logic [31:0] req_value;
  logic [11:0] req_cfg;
  logic [1:0]  req_accept;
  logic [1:0]  done;
  logic [15:0] result;
  logic        busy;
  logic        sh_cs;
  logic        sh_we;
  logic [1:0]  sh_sel;
  logic [15:0] sh_wdata;
  logic [15:0] sh_rdata;

  modport master (
    input  req_valid, req_value, req_cfg, sh_rdata,
    output req_accept, done, result, busy,
    output sh_cs, sh_we, sh_sel, sh_wdata
  );

  modport slave (
    output req_valid, req_value, req_cfg, sh_rdata,
    input  req_accept, done, result, busy,
    input  sh_cs, sh_we, sh_sel, sh_wdata
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one memory-mapped shifter between two
// requesters: latches a job, drives the bus sequence, returns the result.
module shift_arbiter #(
  parameter int SHIFT_LAT = 17,
  parameter int LAT_W     = 5
) (
  input logic           clk,
  input logic           reset,
  shift_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ORIG,
    S_WR_INFO,
    S_RESTART,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic             rr;
  logic             owner;
  logic             gid;
  logic             grant;
  logic [15:0]      gval;
  logic [5:0]       gcfg;
  logic [15:0]      val;
  logic             dir;
  logic [4:0]       cnt;
  logic [LAT_W-1:0] wcnt;
  logic [15:0]      result_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic             cs_q, we_q;
  logic [1:0]       sel_q;
  logic [15:0]      wd_q;
  logic             cs_nx, we_nx;
  logic [1:0]       sel_nx;
  logic [15:0]      wd_nx;

  always_comb begin
    gid = 1'b0;
    unique case (1'b1)
      (&bus.req_valid):            gid = ~rr;
      (bus.req_valid == 2'b10):    gid = 1'b1;
      default:                     gid = 1'b0;
    endcase
  end

  assign grant = (state == S_IDLE) && (|bus.req_valid);
  assign gval  = gid ? bus.req_value[31:16] : bus.req_value[15:0];
  assign gcfg  = gid ? bus.req_cfg[11:6] : bus.req_cfg[5:0];

  // Accept is decoded in the grant cycle itself; held low while in reset.
  assign bus.req_accept = (grant && reset) ? (gid ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (grant) state_nx = S_WR_ORIG;
      S_WR_ORIG: state_nx = S_WR_INFO;
      S_WR_INFO: state_nx = S_RESTART;
      S_RESTART: state_nx = S_WAIT;
      S_WAIT: begin
        if (wcnt == LAT_W'(SHIFT_LAT - 1)) state_nx = S_READ;
      end
      S_READ:    state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    cs_nx  = 1'b0;
    we_nx  = 1'b0;
    sel_nx = 2'b00;
    wd_nx  = 16'h0000;
    unique case (state_nx)
      S_WR_ORIG: begin
        cs_nx  = 1'b1;
        we_nx  = 1'b1;
        sel_nx = 2'b01;
        wd_nx  = gval;
      end
      S_WR_INFO: begin
        cs_nx  = 1'b1;
        we_nx  = 1'b1;
        sel_nx = 2'b00;
        wd_nx  = {dir, 10'b0, cnt};
      end
      S_RESTART: begin
        cs_nx  = 1'b1;
        sel_nx = 2'b11;
      end
      S_WAIT, S_READ: begin
        cs_nx  = 1'b1;
        sel_nx = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr       <= 1'b1;
      owner    <= 1'b0;
      val      <= '0;
      dir      <= 1'b0;
      cnt      <= '0;
      wcnt     <= '0;
      result_q <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      wd_q     <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != S_IDLE);
      cs_q   <= cs_nx;
      we_q   <= we_nx;
      sel_q  <= sel_nx;
      wd_q   <= wd_nx;
      done_q <= 2'b00;
      if (grant) begin
        rr    <= gid;
        owner <= gid;
        val   <= gval;
        dir   <= gcfg[5];
        cnt   <= gcfg[4:0];
      end
      if (state == S_WAIT) wcnt <= wcnt + LAT_W'(1);
      else                 wcnt <= '0;
      if (state == S_READ) begin
        result_q <= bus.sh_rdata;
        done_q   <= owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.sh_cs    = cs_q;
  assign bus.sh_we    = we_q;
  assign bus.sh_sel   = sel_q;
  assign bus.sh_wdata = wd_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: random and directed jobs, a peripheral model,
// a cycle-timeline reference and a result scoreboard.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  shift_arbiter_if sif ();

  shift_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: needs 16 cycles after restart before its result is valid.
  logic [15:0] p_orig = '0;
  logic [15:0] p_info = '0;
  logic [15:0] p_res  = '0;
  int          p_cnt  = 0;

  always @(posedge clk) begin
    if (p_cnt < 1000) p_cnt <= p_cnt + 1;
    if (sif.sh_cs && sif.sh_we && sif.sh_sel == 2'b01) p_orig <= sif.sh_wdata;
    if (sif.sh_cs && sif.sh_we && sif.sh_sel == 2'b00) p_info <= sif.sh_wdata;
    if (sif.sh_cs && !sif.sh_we && sif.sh_sel == 2'b11) begin
      p_cnt <= 0;
      if (p_info[15]) p_res <= p_orig >> ((p_info[14:0] > 15) ? 15 : p_info[3:0]);
      else            p_res <= p_orig << ((p_info[14:0] > 15) ? 15 : p_info[3:0]);
    end
  end

  assign sif.sh_rdata = (sif.sh_cs && sif.sh_sel == 2'b10 && p_cnt >= 16)
                        ? p_res : 16'hDEAD;

  typedef struct {
    int          g;
    logic [15:0] val;
    logic [15:0] info;
    logic [15:0] res;
  } job_t;

  job_t q[$];
  job_t cur;
  int   checks = 0;
  int   errors = 0;
  int   acc    = 0;
  bit   active = 0;
  int   rr_m   = 1;
  bit   end_req = 0;
  bit   end_done = 0;
  logic [1:0] auto_drop = 2'b11;

  function automatic logic [15:0] ref_shift(logic [15:0] v, logic d, logic [4:0] n);
    int s;
    s = (n > 15) ? 15 : int'(n);
    return d ? (v >> s) : (v << s);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int          k;
    int          g;
    logic [1:0]  exp_acc;
    logic [3:0]  exp_bus;
    logic [15:0] exp_wd;
    bit          wd_care;
    job_t        j;
    if (!reset) begin
      q.delete();
      active = 0;
      rr_m   = 1;
      chk("reset_outputs",
          {sif.req_accept, sif.done, sif.busy, sif.sh_cs, sif.sh_we, sif.sh_sel},
          32'h0);
      chk("reset_data", {sif.result, sif.sh_wdata}, 32'h0);
    end else begin
      k = cyc - acc;
      exp_acc = 2'b00;
      if ((!active || k >= 23) && sif.req_valid != 2'b00) begin
        if (sif.req_valid == 2'b11) g = (rr_m == 0) ? 1 : 0;
        else                        g = sif.req_valid[1] ? 1 : 0;
        exp_acc[g] = 1'b1;
      end
      if (exp_acc != 0 || sif.req_accept != 0)
        chk("req_accept", 32'(sif.req_accept), 32'(exp_acc));
      if (exp_acc != 0) begin
        cur.g    = g;
        cur.val  = sif.req_value[g*16 +: 16];
        cur.info = {sif.req_cfg[g*6+5], 10'b0, sif.req_cfg[g*6 +: 5]};
        cur.res  = ref_shift(cur.val, sif.req_cfg[g*6+5], sif.req_cfg[g*6 +: 5]);
        q.push_back(cur);
        acc    = cyc;
        active = 1;
        rr_m   = g;
        k      = 0;
      end
      exp_bus = 4'b0000;
      exp_wd  = 16'h0000;
      wd_care = 1;
      if (active && k == 1) begin
        exp_bus = 4'b1101;
        exp_wd  = cur.val;
      end else if (active && k == 2) begin
        exp_bus = 4'b1100;
        exp_wd  = cur.info;
      end else if (active && k == 3) begin
        exp_bus = 4'b1011;
        wd_care = 0;
      end else if (active && k >= 4 && k <= 21) begin
        exp_bus = 4'b1010;
        wd_care = 0;
      end
      chk("bus_ctrl", 32'({sif.sh_cs, sif.sh_we, sif.sh_sel}), 32'(exp_bus));
      if (wd_care) chk("bus_wdata", 32'(sif.sh_wdata), 32'(exp_wd));
      chk("busy", 32'(sif.busy), 32'(active && k >= 1 && k <= 22));
      chk("done_time", 32'(sif.done),
          (active && k == 22) ? (cur.g ? 32'd2 : 32'd1) : 32'd0);
      if (sif.done != 2'b00) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 32'(sif.done), 32'h0);
        end else begin
          j = q.pop_front();
          chk("done_owner", 32'(sif.done), j.g ? 32'd2 : 32'd1);
          chk("result", 32'(sif.result), 32'(j.res));
        end
      end
    end
    if (end_req && !end_done) begin
      chk("queue_drained", 32'(q.size()), 32'h0);
      end_done = 1;
    end
  end

  task automatic tick(int n = 1);
    logic [1:0] a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = sif.req_accept;
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (a[g]) begin
          sif.req_value[g*16 +: 16] = 16'($urandom);
          sif.req_cfg[g*6 +: 6]     = 6'($urandom);
        end
      end
      sif.req_valid = sif.req_valid & ~(sif.done & auto_drop);
    end
  endtask

  initial begin
    logic [1:0] nv;
    reset         = 1'b0;
    sif.req_valid = '0;
    sif.req_value = '0;
    sif.req_cfg   = '0;
    tick(3);
    reset = 1'b1;
    tick(1);

    // simultaneous from reset: requester 0 first, then 1
    sif.req_value = {16'h00F0, 16'h1234};
    sif.req_cfg   = {1'b0, 5'd2, 1'b1, 5'd3};
    sif.req_valid = 2'b11;
    tick(50);

    // both held across several jobs: grants alternate
    auto_drop     = 2'b00;
    sif.req_valid = 2'b11;
    tick(23 * 4 + 5);
    sif.req_valid = 2'b00;
    auto_drop     = 2'b11;
    tick(25);

    // single job on requester 0
    sif.req_value[15:0] = 16'h0001;
    sif.req_cfg[5:0]    = {1'b0, 5'd4};
    sif.req_valid       = 2'b01;
    tick(26);

    // count above 15 on requester 1
    sif.req_value[31:16] = 16'h8000;
    sif.req_cfg[11:6]    = {1'b1, 5'd20};
    sif.req_valid        = 2'b10;
    tick(26);

    // abort in WAIT, then requester 0 favoured after release
    sif.req_valid = 2'b10;
    tick(10);
    #2 reset = 1'b0;
    sif.req_valid = 2'b11;
    tick(2);
    reset = 1'b1;
    tick(50);

    // requester drops valid two cycles after accept
    sif.req_valid = 2'b01;
    tick(2);
    sif.req_valid = 2'b00;
    tick(26);

    for (int n = 0; n < 14; n++) begin
      nv = 2'($urandom_range(1, 3));
      for (int g = 0; g < 2; g++) begin
        if (nv[g] && !sif.req_valid[g]) begin
          sif.req_value[g*16 +: 16] = 16'($urandom);
          sif.req_cfg[g*6 +: 6]     = 6'($urandom);
        end
      end
      sif.req_valid = sif.req_valid | nv;
      tick($urandom_range(5, 30));
    end
    tick(60);
    sif.req_valid = 2'b00;
    tick(5);

    end_req = 1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
